// File: rtl/sequence_controller.sv
// rtl/sequence_controller.sv - instruction-cycle sequencer driving the T-state counter
// Walks fetch/indirect/execute/interrupt phases and commands the external sequence counter.
module sequence_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  seq_in,
  input  logic [15:0] ir_in,
  input  logic        exec_done,
  input  logic        ien,
  input  logic        fgi,
  input  logic        fgo,
  output logic        sc_inc,
  output logic        sc_clr,
  output logic [15:0] t,
  output logic [7:0]  d,
  output logic        i_bit,
  output logic        r_flag,
  output logic        running,
  output logic        seq_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_INDIRECT,
    S_EXECUTE,
    S_INTERRUPT,
    S_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic        r_sc_inc;
  logic        r_sc_clr;
  logic [7:0]  r_d;
  logic        r_i_bit;
  logic        r_r_flag;
  logic        r_seq_err;

  logic        w_clr;
  logic        w_clr_next;
  logic [7:0]  w_d;
  logic        w_i_bit;
  logic        w_r_flag;
  logic        w_seq_err;
  logic        w_counting;
  logic        w_running;

  // While a clear is in flight seq_in still holds the previous phase's count,
  // so T-state decisions are only taken once the counter has restarted.
  assign w_counting = ~r_sc_clr;

  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_d          = r_d;
    w_i_bit      = r_i_bit;
    w_r_flag     = r_r_flag;
    w_seq_err    = r_seq_err;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start) begin
          w_next_state = S_FETCH;
          w_seq_err    = 1'b0;
        end
      end
      S_FETCH: begin
        if (w_counting && seq_in == 4'd2) begin
          w_d     = 8'(8'h01 << ir_in[14:12]);
          w_i_bit = ir_in[15];
          if (ir_in[15] && ir_in[14:12] != 3'b111)
            w_next_state = S_INDIRECT;
          else
            w_next_state = S_EXECUTE;
        end
      end
      S_INDIRECT: begin
        if (w_counting && seq_in == 4'd3)
          w_next_state = S_EXECUTE;
      end
      S_EXECUTE: begin
        if (r_d[7] && !r_i_bit && ir_in == 16'h7001 && seq_in == 4'd3) begin
          w_next_state = S_HALT;
        end else if (exec_done) begin
          w_clr = 1'b1;
          if (ien && (fgi || fgo)) begin
            w_next_state = S_INTERRUPT;
            w_r_flag     = 1'b1;
          end else begin
            w_next_state = S_FETCH;
          end
        end else if (seq_in == 4'd15) begin
          w_next_state = S_IDLE;
          w_seq_err    = 1'b1;
        end
      end
      S_INTERRUPT: begin
        if (w_counting && seq_in == 4'd2) begin
          w_clr        = 1'b1;
          w_r_flag     = 1'b0;
          w_next_state = S_FETCH;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Counter commands are registered for the state being entered, so inc and clr stay exclusive.
  assign w_clr_next = w_clr || (w_next_state == S_IDLE) || (w_next_state == S_HALT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_sc_inc  <= 1'b0;
      r_sc_clr  <= 1'b1;
      r_d       <= 8'h00;
      r_i_bit   <= 1'b0;
      r_r_flag  <= 1'b0;
      r_seq_err <= 1'b0;
    end else begin
      r_state   <= w_next_state;
      r_sc_inc  <= ~w_clr_next;
      r_sc_clr  <= w_clr_next;
      r_d       <= w_d;
      r_i_bit   <= w_i_bit;
      r_r_flag  <= w_r_flag;
      r_seq_err <= w_seq_err;
    end
  end

  assign w_running = (r_state == S_FETCH) || (r_state == S_INDIRECT) ||
                     (r_state == S_EXECUTE) || (r_state == S_INTERRUPT);

  assign running = w_running;
  assign t       = w_running ? 16'(16'h0001 << seq_in) : 16'h0000;
  assign sc_inc  = r_sc_inc;
  assign sc_clr  = r_sc_clr;
  assign d       = r_d;
  assign i_bit   = r_i_bit;
  assign r_flag  = r_r_flag;
  assign seq_err = r_seq_err;

endmodule

// File: tb/tb_sequence_controller.sv
// tb/tb_sequence_controller.sv - directed vector bench for sequence_controller
// A small sequence-counter model feeds seq_in from the registered sc_inc/sc_clr commands.
module tb_sequence_controller;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  seq_in;
  logic [15:0] ir_in;
  logic        exec_done;
  logic        ien;
  logic        fgi;
  logic        fgo;
  logic        sc_inc;
  logic        sc_clr;
  logic [15:0] t;
  logic [7:0]  d;
  logic        i_bit;
  logic        r_flag;
  logic        running;
  logic        seq_err;

  int total = 0;
  int bad   = 0;

  sequence_controller dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .seq_in    (seq_in),
    .ir_in     (ir_in),
    .exec_done (exec_done),
    .ien       (ien),
    .fgi       (fgi),
    .fgo       (fgo),
    .sc_inc    (sc_inc),
    .sc_clr    (sc_clr),
    .t         (t),
    .d         (d),
    .i_bit     (i_bit),
    .r_flag    (r_flag),
    .running   (running),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        ed;
    logic        ie;
    logic        fi;
    logic        fo;
    logic [15:0] ir;
    logic        inc;
    logic        clr;
    logic        run;
    logic [7:0]  d;
    logic        ib;
    logic        rf;
    logic        err;
    logic [15:0] t;
  } vec_t;

  vec_t v[$];

  function automatic vec_t mk(input logic st, input logic ed, input logic ie, input logic fi,
                              input logic fo, input logic [15:0] ir, input logic inc,
                              input logic clr, input logic run, input logic [7:0] dd,
                              input logic ib, input logic rf, input logic err,
                              input logic [15:0] tt);
    vec_t r;
    r.st = st; r.ed = ed; r.ie = ie; r.fi = fi; r.fo = fo; r.ir = ir;
    r.inc = inc; r.clr = clr; r.run = run; r.d = dd; r.ib = ib; r.rf = rf;
    r.err = err; r.t = tt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Counter model: acts on the commands that were present before the edge.
  task automatic tick();
    logic c;
    logic ii;
    c  = sc_clr;
    ii = sc_inc;
    @(posedge clk);
    #1;
    if (c) seq_in = 4'd0;
    else if (ii) seq_in = seq_in + 4'd1;
    #1;
  endtask

  task automatic chk_all(input string p, input logic inc, input logic clr, input logic run,
                         input logic [7:0] dd, input logic ib, input logic rf, input logic err,
                         input logic [15:0] tt);
    chk({p, " sc_inc"},  {15'd0, sc_inc},  {15'd0, inc});
    chk({p, " sc_clr"},  {15'd0, sc_clr},  {15'd0, clr});
    chk({p, " running"}, {15'd0, running}, {15'd0, run});
    chk({p, " d"},       {8'd0, d},        {8'd0, dd});
    chk({p, " i_bit"},   {15'd0, i_bit},   {15'd0, ib});
    chk({p, " r_flag"},  {15'd0, r_flag},  {15'd0, rf});
    chk({p, " seq_err"}, {15'd0, seq_err}, {15'd0, err});
    chk({p, " t"},       t,                tt);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; seq_in = 4'd0; ir_in = 16'h2005;
    exec_done = 1'b0; ien = 1'b0; fgi = 1'b0; fgo = 1'b0;

    // Direct instruction, normal completion at T4
    v.push_back(mk(1,0,0,0,0,16'h2005, 1,0,1,8'h00,0,0,0,16'h0001));
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h00,0,0,0,16'h0002));
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h00,0,0,0,16'h0004));
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h04,0,0,0,16'h0008));
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h04,0,0,0,16'h0010));
    v.push_back(mk(0,1,0,0,0,16'h2005, 0,1,1,8'h04,0,0,0,16'h0020));
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h04,0,0,0,16'h0001));
    // Indirect instruction, exec_done with pending interrupt
    v.push_back(mk(0,0,0,0,0,16'hA010, 1,0,1,8'h04,0,0,0,16'h0002));
    v.push_back(mk(0,0,0,0,0,16'hA010, 1,0,1,8'h04,0,0,0,16'h0004));
    v.push_back(mk(0,0,0,0,0,16'hA010, 1,0,1,8'h04,1,0,0,16'h0008));
    v.push_back(mk(0,0,0,0,0,16'hA010, 1,0,1,8'h04,1,0,0,16'h0010));
    v.push_back(mk(0,1,1,1,0,16'hA010, 0,1,1,8'h04,1,1,0,16'h0020));
    v.push_back(mk(0,0,0,0,0,16'hA010, 1,0,1,8'h04,1,1,0,16'h0001));
    v.push_back(mk(0,0,0,0,0,16'hA010, 1,0,1,8'h04,1,1,0,16'h0002));
    v.push_back(mk(0,0,0,0,0,16'hA010, 1,0,1,8'h04,1,1,0,16'h0004));
    v.push_back(mk(0,0,0,0,0,16'hA010, 0,1,1,8'h04,1,0,0,16'h0008));
    // Halt instruction, exec_done ignored in the halt cycle, then resume
    v.push_back(mk(0,0,0,0,0,16'h7001, 1,0,1,8'h04,1,0,0,16'h0001));
    v.push_back(mk(0,0,0,0,0,16'h7001, 1,0,1,8'h04,1,0,0,16'h0002));
    v.push_back(mk(0,0,0,0,0,16'h7001, 1,0,1,8'h04,1,0,0,16'h0004));
    v.push_back(mk(0,0,0,0,0,16'h7001, 1,0,1,8'h80,0,0,0,16'h0008));
    v.push_back(mk(0,1,0,0,0,16'h7001, 0,1,0,8'h80,0,0,0,16'h0000));
    v.push_back(mk(0,0,0,0,0,16'h7001, 0,1,0,8'h80,0,0,0,16'h0000));
    v.push_back(mk(1,0,0,0,0,16'h7001, 1,0,1,8'h80,0,0,0,16'h0001));
    // Execute timeout: never sees exec_done
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h80,0,0,0,16'h0002));
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h80,0,0,0,16'h0004));
    v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h04,0,0,0,16'h0008));
    for (int k = 4; k <= 15; k++) begin
      v.push_back(mk(0,0,0,0,0,16'h2005, 1,0,1,8'h04,0,0,0,16'(16'h0001 << k)));
    end
    v.push_back(mk(0,0,0,0,0,16'h2005, 0,1,0,8'h04,0,0,1,16'h0000));
    v.push_back(mk(0,0,0,0,0,16'h2005, 0,1,0,8'h04,0,0,1,16'h0000));
    v.push_back(mk(1,0,0,0,0,16'h2005, 1,0,1,8'h04,0,0,0,16'h0001));

    tick();
    chk_all("reset", 0, 1, 0, 8'h00, 0, 0, 0, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < v.size(); i++) begin
      start = v[i].st; exec_done = v[i].ed; ien = v[i].ie; fgi = v[i].fi;
      fgo = v[i].fo; ir_in = v[i].ir;
      tick();
      chk_all($sformatf("row%0d", i), v[i].inc, v[i].clr, v[i].run, v[i].d,
              v[i].ib, v[i].rf, v[i].err, v[i].t);
    end
    start = 1'b0; exec_done = 1'b0; ien = 1'b0; fgi = 1'b0; fgo = 1'b0;

    // exec_done arriving exactly at T15 is a normal completion, not an error
    ir_in = 16'h2005;
    for (int k = 0; k < 15; k++) tick();
    chk("t15 pre t", t, 16'h8000);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk_all("t15 done", 0, 1, 1, 8'h04, 0, 0, 0, 16'h0001);
    tick();
    chk_all("t15 next", 1, 0, 1, 8'h04, 0, 0, 0, 16'h0001);

    // Reset mid-execute at T5 overrides start and exec_done
    for (int k = 0; k < 5; k++) tick();
    chk("mid pre t", t, 16'h0020);
    reset = 1'b1; start = 1'b1; exec_done = 1'b1;
    tick();
    chk_all("mid reset", 0, 1, 0, 8'h00, 0, 0, 0, 16'h0000);
    reset = 1'b0; start = 1'b0; exec_done = 1'b0;
    tick();
    chk_all("post reset", 0, 1, 0, 8'h00, 0, 0, 0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
